// File: rtl/axis_packet_master_if.sv
// AXI4-Stream handshake bundle used by axis_packet_master.
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror view.
interface axis_packet_master_if #(
  parameter int DATA_WIDTH = 256
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_master.sv
// AXI4-Stream burst generator: after one start pulse emits num_packets packets of packet_len
// beats carrying seed + running beat index. Define AXIS_PKT_HDR_EN to prefix each packet with a header beat.
module axis_packet_master #(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  resentn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic [CNT_WIDTH-1:0]  num_packets,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_packet_master_if.master  axis,
  output logic                  busy,
  output logic                  done
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t                state_r, state_nxt_s;
  logic [LEN_WIDTH-1:0]  len_r, len_nxt_s, beat_cnt_r, beat_cnt_nxt_s;
  logic [CNT_WIDTH-1:0]  num_r, num_nxt_s, pkt_cnt_r, pkt_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] seed_r, seed_nxt_s, beat_idx_r, beat_idx_nxt_s;
  logic [GAP_W-1:0]      gap_cnt_r, gap_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
  logic                  tvalid_r, tvalid_nxt_s, tlast_r, tlast_nxt_s;
  logic                  busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic                  hs_s, accept_s, final_s;

  // Beat counter value that carries tlast (header mode adds one leading beat)
  function automatic logic [LEN_WIDTH-1:0] last_beat(input logic [LEN_WIDTH-1:0] len);
`ifdef AXIS_PKT_HDR_EN
    return len;
`else
    return len - LEN_WIDTH'(1'b1);
`endif
  endfunction

`ifdef AXIS_PKT_HDR_EN
  function automatic logic [DATA_WIDTH-1:0] header_beat(input logic [CNT_WIDTH-1:0] pkt,
                                                        input logic [LEN_WIDTH-1:0] len);
    logic [DATA_WIDTH-1:0] h;
    h       = {DATA_WIDTH{1'b0}};
    h[15:8] = 8'(pkt);
    h[7:0]  = 8'(len);
    return h;
  endfunction
`endif

  assign hs_s     = tvalid_r & axis.tready;
  // A start coinciding with the done pulse belongs to the finished burst and is dropped
  assign accept_s = start & ~done_r & (packet_len != {LEN_WIDTH{1'b0}})
                    & (num_packets != {CNT_WIDTH{1'b0}});
  assign final_s  = ((pkt_cnt_r + CNT_WIDTH'(1'b1)) == num_r);

  // State, captured burst parameters, counters and registered stream outputs
  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      state_r    <= IDLE;
      len_r      <= {LEN_WIDTH{1'b0}};
      num_r      <= {CNT_WIDTH{1'b0}};
      seed_r     <= {DATA_WIDTH{1'b0}};
      beat_idx_r <= {DATA_WIDTH{1'b0}};
      beat_cnt_r <= {LEN_WIDTH{1'b0}};
      pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
      gap_cnt_r  <= {GAP_W{1'b0}};
      tdata_r    <= {DATA_WIDTH{1'b0}};
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      len_r      <= len_nxt_s;
      num_r      <= num_nxt_s;
      seed_r     <= seed_nxt_s;
      beat_idx_r <= beat_idx_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      pkt_cnt_r  <= pkt_cnt_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      tdata_r    <= tdata_nxt_s;
      tvalid_r   <= tvalid_nxt_s;
      tlast_r    <= tlast_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SEND;
        else          state_nxt_s = IDLE;
      end
      SEND: begin
        if (hs_s && tlast_r) begin
          if (final_s)              state_nxt_s = IDLE;
          else if (GAP_CYCLES > 0)  state_nxt_s = GAP;
          else                      state_nxt_s = SEND;
        end else begin
          state_nxt_s = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt_s = SEND;
        else                       state_nxt_s = GAP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter updates and the output values presented from the next cycle on
  always_comb begin
    len_nxt_s      = len_r;
    num_nxt_s      = num_r;
    seed_nxt_s     = seed_r;
    beat_idx_nxt_s = beat_idx_r;
    beat_cnt_nxt_s = beat_cnt_r;
    pkt_cnt_nxt_s  = pkt_cnt_r;
    gap_cnt_nxt_s  = {GAP_W{1'b0}};
    done_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          len_nxt_s      = packet_len;
          num_nxt_s      = num_packets;
          seed_nxt_s     = seed;
          beat_idx_nxt_s = {DATA_WIDTH{1'b0}};
          beat_cnt_nxt_s = {LEN_WIDTH{1'b0}};
          pkt_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
        end else begin
          len_nxt_s = len_r;
        end
      end
      SEND: begin
        if (hs_s) begin
`ifdef AXIS_PKT_HDR_EN
          // The header beat does not advance the pattern index
          if (beat_cnt_r == {LEN_WIDTH{1'b0}}) beat_idx_nxt_s = beat_idx_r;
          else                                 beat_idx_nxt_s = beat_idx_r + DATA_WIDTH'(1'b1);
`else
          beat_idx_nxt_s = beat_idx_r + DATA_WIDTH'(1'b1);
`endif
          if (tlast_r) begin
            beat_cnt_nxt_s = {LEN_WIDTH{1'b0}};
            pkt_cnt_nxt_s  = pkt_cnt_r + CNT_WIDTH'(1'b1);
            done_nxt_s     = final_s;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + LEN_WIDTH'(1'b1);
          end
        end else begin
          beat_idx_nxt_s = beat_idx_r;
        end
      end
      GAP: begin
        if (gap_cnt_r != GAP_LAST) gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1'b1);
        else                       gap_cnt_nxt_s = {GAP_W{1'b0}};
      end
      default: done_nxt_s = 1'b0;
    endcase

    busy_nxt_s   = (state_nxt_s != IDLE);
    tvalid_nxt_s = (state_nxt_s == SEND);
    tlast_nxt_s  = tvalid_nxt_s & (beat_cnt_nxt_s == last_beat(len_nxt_s));
`ifdef AXIS_PKT_HDR_EN
    tdata_nxt_s  = !tvalid_nxt_s ? {DATA_WIDTH{1'b0}} :
                   (beat_cnt_nxt_s == {LEN_WIDTH{1'b0}}) ? header_beat(pkt_cnt_nxt_s, len_nxt_s) :
                   seed_nxt_s + beat_idx_nxt_s;
`else
    tdata_nxt_s  = tvalid_nxt_s ? seed_nxt_s + beat_idx_nxt_s : {DATA_WIDTH{1'b0}};
`endif
  end

  assign axis.tdata  = tdata_r;
  assign axis.tvalid = tvalid_r;
  assign axis.tlast  = tlast_r;
  assign busy        = busy_r;
  assign done        = done_r;
endmodule

// File: doc/axis_packet_master.md
Name: axis_packet_master

Overview:
- Parametrised AXI4-Stream master that emits a burst of NUM packets, each of LEN beats, after a single start pulse.
- Data is a deterministic pattern: a seed plus a running beat index.
- Full AXI-Stream source handshake:
  - tvalid is held until accepted.
  - tdata and tlast are stable while stalled.
  - tlast is asserted on the final beat of every packet.
- Sits between control logic and any AXI-Stream sink, for traffic generation and link bring-up.

Parameters:
DATA_WIDTH, 256, tdata width in bits (>= 16)
LEN_WIDTH, 8, width of the packet_len input; max packet length 2^LEN_WIDTH-1 beats
CNT_WIDTH, 8, width of the num_packets input
GAP_CYCLES, 0, idle cycles (tvalid low) inserted after each packet's last beat; 0 = back-to-back

Ports:
clk  input  1  clock, all logic on rising edge
resentn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a burst; sampled only in IDLE
packet_len  input  LEN_WIDTH  beats per packet, captured on accepted start
num_packets  input  CNT_WIDTH  packets per burst, captured on accepted start
seed  input  DATA_WIDTH  pattern base, captured on accepted start
tready  input  1  sink ready
tdata  output  DATA_WIDTH  stream data
tvalid  output  1  stream valid
tlast  output  1  last beat of packet
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the final handshake of the burst

Behaviour:
- Reset (resentn low, asynchronous):
  - tdata = 0, tvalid = 0, tlast = 0, busy = 0, done = 0.
  - All counters clear; state = IDLE.
  - Reset mid-burst abandons the burst immediately. No tlast is sent.
- States: IDLE, SEND, GAP.
- IDLE:
  - On start=1 with packet_len != 0 and num_packets != 0:
    - Capture packet_len, num_packets and seed.
    - beat_idx = 0, beat_cnt = 0, pkt_cnt = 0.
    - busy = 1; go to SEND.
  - tvalid rises the cycle after start (latency 1).
  - start with a zero length or zero count is ignored: busy stays 0, no done pulse.
- SEND:
  - tvalid = 1; tdata = seed + beat_idx, truncated modulo 2^DATA_WIDTH.
  - tlast = 1 exactly when beat_cnt == len-1.
  - Handshake = tvalid & tready.
  - Without a handshake, tdata, tlast and tvalid hold unchanged (AXI rule). tvalid never drops while unaccepted.
  - On handshake:
    - beat_idx increments; it runs continuously across packets and wraps modulo 2^DATA_WIDTH.
    - beat_cnt increments, or clears to 0 if the beat was tlast.
  - On the tlast handshake, pkt_cnt increments, then:
    - If pkt_cnt reaches num: tvalid = 0, tlast = 0, busy = 0, done = 1 for one cycle; go to IDLE.
    - Else if GAP_CYCLES > 0: tvalid = 0; go to GAP.
    - Else stay in SEND; the next packet's first beat is presented in the following cycle with no bubble.
- GAP:
  - tvalid = 0; count GAP_CYCLES clocks, then return to SEND.
  - busy stays 1.
- Packet length 1: every beat carries tlast = 1.
- start while busy is ignored; captured values are unaffected by input changes during a burst.
- tready may toggle arbitrarily. Data order and beat count must be exact regardless of stall pattern.
- done and start in the same cycle: done goes out and state returns to IDLE. That start is not accepted; a new start is accepted from the next cycle.

Optional Feature:
- Macro: AXIS_PKT_HDR_EN.
- When defined, the first beat of each packet is a header instead of pattern data:
  - tdata[DATA_WIDTH-1:16] = 0.
  - tdata[15:8] = packet index mod 256.
  - tdata[7:0] = len mod 256.
  - The header does not consume a beat_idx value.
  - Payload beats follow; the packet totals len+1 beats, with tlast on the final payload beat.
- When undefined, packets are exactly len pattern beats. No header logic is synthesised.

Test Plan:
1. Basic burst: seed=0x10, len=4, num=2, GAP=0, tready=1 -> 8 consecutive beats with tdata 0x10..0x17; tlast on beats 4 and 8; done pulses the cycle after beat 8; busy high throughout.
2. Backpressure: len=3, num=1, tready pattern 1,0,0,1,0,1 -> tdata/tlast stable during low-tready cycles; exactly 3 handshakes with data seed, seed+1, seed+2; tlast only with seed+2.
3. Gap insertion: GAP_CYCLES=2, len=2, num=3 -> tvalid low for exactly 2 cycles between packets; no gap after packet 3; done once.
4. Boundaries:
   - len=1, num=3 -> tlast on every beat.
   - start with len=0 -> no activity.
   - seed = all-ones, len=2 -> second beat is 0 (wrap).
5. Reset mid-burst: assert resentn=0 during beat 2 of 5 -> all outputs 0 asynchronously. After release, a new start runs from beat_idx 0 normally.
6. With AXIS_PKT_HDR_EN defined: len=2, num=2, seed=0 -> beats: hdr(idx0, len2), 0, 1, hdr(idx1, len2), 2, 3; tlast on beats 3 and 6.
